// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the codec capture/playback paths.
//   cap_state_t : capture controller states
//   MODE_*      : stereo-to-mono selection codes
//   SAMPLE_W    : codec sample width
package audio_pkg;

  localparam int SAMPLE_W = 24;

  localparam logic [1:0] MODE_MIX   = 2'b00;
  localparam logic [1:0] MODE_LEFT  = 2'b01;
  localparam logic [1:0] MODE_RIGHT = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DONE
  } cap_state_t;

endpackage

// File: rtl/sample_mono.sv
// sample_mono: combinational stereo-to-mono conversion with saturating magnitude.
//   mode  : MODE_MIX (and 2'b11) = floor((L+R)/2), MODE_LEFT = L, MODE_RIGHT = R
//   left  : left sample, two's complement
//   right : right sample, two's complement
//   mono  : converted sample, two's complement
//   mag   : |mono|, with |-2^(DATA_W-1)| saturated to 2^(DATA_W-1)-1
module sample_mono
  import audio_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] left,
  input  logic [DATA_W-1:0] right,
  output logic [DATA_W-1:0] mono,
  output logic [DATA_W-2:0] mag
);

  logic [DATA_W-1:0] half_l;
  logic [DATA_W-1:0] half_r;
  logic [DATA_W-1:0] mix;

  always_comb begin
    // floor((L+R)/2) formed as (L>>>1)+(R>>>1)+(L[0]&R[0]); identical to the
    // DATA_W+1-bit add-then-shift, but stays in DATA_W bits without overflow.
    half_l = {left[DATA_W-1], left[DATA_W-1:1]};
    half_r = {right[DATA_W-1], right[DATA_W-1:1]};
    mix    = half_l + half_r + {{(DATA_W-1){1'b0}}, left[0] & right[0]};

    case (mode)
      MODE_LEFT:  mono = left;
      MODE_RIGHT: mono = right;
      default:    mono = mix;
    endcase

    if (!mono[DATA_W-1])
      mag = mono[DATA_W-2:0];
    else if (mono[DATA_W-2:0] == '0)
      mag = '1;
    else
      mag = ~mono[DATA_W-2:0] + {{(DATA_W-2){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/audio_capture.sv
// audio_capture: drains the codec read FIFO into a sample RAM as mono samples.
//   clk, reset            : system clock, async active-low reset
//   start, abort          : single-cycle control pulses (abort wins)
//   mode                  : stereo-to-mono selection
//   read_ready, readdata_*: show-ahead codec FIFO interface; read pops one pair
//   mem_wr_en/addr/wdata  : sample RAM write port, one cycle after each read
//   busy, done            : registered state decodes
//   sample_count, peak    : samples written and max |sample| of current/last capture
module audio_capture
  import audio_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   sample_count,
  output logic [DATA_W-2:0] peak
);

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  cap_state_t        state, state_nx;
  logic [DATA_W-1:0] mono;
  logic [DATA_W-2:0] mag;
  logic              last_slot;
  logic              start_cap;

  sample_mono #(.DATA_W(DATA_W)) u_mono (
    .mode  (mode),
    .left  (readdata_left),
    .right (readdata_right),
    .mono  (mono),
    .mag   (mag)
  );

  always_comb begin
    read      = (state == CAPTURE) && read_ready && !abort && !sample_count[ADDR_W];
    last_slot = (sample_count[ADDR_W-1:0] == '1);
    state_nx  = state;
    case (state)
      IDLE:    if (start && !abort) state_nx = CAPTURE;
      CAPTURE: if (abort) state_nx = IDLE;
               else if (read && last_slot) state_nx = DONE;
      DONE:    if (abort) state_nx = IDLE;
               else if (start) state_nx = CAPTURE;
      default: state_nx = IDLE;
    endcase
    start_cap = (state != CAPTURE) && (state_nx == CAPTURE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_wr_en    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      sample_count <= '0;
      peak         <= '0;
    end else begin
      state     <= state_nx;
      busy      <= (state_nx == CAPTURE);
      done      <= (state_nx == DONE);
      mem_wr_en <= read;
      // start_cap and read are mutually exclusive (read needs CAPTURE already)
      if (start_cap) begin
        sample_count <= '0;
        peak         <= '0;
      end else if (read) begin
        mem_addr     <= sample_count[ADDR_W-1:0];
        mem_wdata    <= mono;
        sample_count <= sample_count + CNT_ONE;
        if (mag > peak) peak <= mag;
      end
    end
  end

endmodule

// File: tb/tb_audio_capture.sv
module tb_audio_capture;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [1:0]  mode;
  logic        read_ready;
  logic [23:0] readdata_left;
  logic [23:0] readdata_right;
  logic        read;
  logic        mem_wr_en;
  logic [3:0]  mem_addr;
  logic [23:0] mem_wdata;
  logic        busy;
  logic        done;
  logic [4:0]  sample_count;
  logic [22:0] peak;

  int checks = 0;
  int errors = 0;

  audio_capture #(.DATA_W(24), .ADDR_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .mode           (mode),
    .read_ready     (read_ready),
    .readdata_left  (readdata_left),
    .readdata_right (readdata_right),
    .read           (read),
    .mem_wr_en      (mem_wr_en),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .busy           (busy),
    .done           (done),
    .sample_count   (sample_count),
    .peak           (peak)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mixing vectors: mode, L, R, expected wdata, expected peak after the write
  typedef struct {
    logic [1:0]  m;
    logic [23:0] l;
    logic [23:0] r;
    logic [23:0] wd;
    logic [22:0] pk;
  } vec_t;

  vec_t vecs[8] = '{
    '{2'b00, 24'h000010, 24'h000030, 24'h000020, 23'h000020},
    '{2'b01, 24'hFFFF00, 24'h000001, 24'hFFFF00, 23'h000100},
    '{2'b10, 24'h7FFFFF, 24'h000005, 24'h000005, 23'h000100},
    '{2'b11, 24'h000003, 24'h000000, 24'h000001, 23'h000100},
    '{2'b00, 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 23'h000100},
    '{2'b00, 24'h800000, 24'h800000, 24'h800000, 23'h7FFFFF},
    '{2'b00, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 23'h7FFFFF},
    '{2'b00, 24'h7FFFFF, 24'h000001, 24'h400000, 23'h7FFFFF}
  };

  logic [4:0] rr_pat = 5'b01101; // applied LSB first: 1,0,1,1,0

  initial begin
    int pulses;
    int nwr;

    reset          = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    mode           = 2'b00;
    read_ready     = 1'b0;
    readdata_left  = '0;
    readdata_right = '0;
    #2;
    chk("rst_read",  {31'd0, read},      32'd0);
    chk("rst_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("rst_addr",  {28'd0, mem_addr},  32'd0);
    chk("rst_wdata", {8'd0, mem_wdata},  32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_done",  {31'd0, done},      32'd0);
    chk("rst_count", {27'd0, sample_count}, 32'd0);
    chk("rst_peak",  {9'd0, peak},       32'd0);
    #1 reset = 1'b1;
    tick();

    // capture with the mixing vector table, read_ready held high
    mode = vecs[0].m; readdata_left = vecs[0].l; readdata_right = vecs[0].r;
    read_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_busy",  {31'd0, busy},      32'd1);
    chk("a_read",  {31'd0, read},      32'd1);
    chk("a_wr_en", {31'd0, mem_wr_en}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      mode = vecs[i].m; readdata_left = vecs[i].l; readdata_right = vecs[i].r;
      tick();
      chk("a_wr_en", {31'd0, mem_wr_en}, 32'd1);
      chk("a_addr",  {28'd0, mem_addr},  i);
      chk("a_wdata", {8'd0, mem_wdata},  {8'd0, vecs[i].wd});
      chk("a_peak",  {9'd0, peak},       {9'd0, vecs[i].pk});
    end
    chk("a_count", {27'd0, sample_count}, 32'd8);

    // abort and start together: abort wins, start is ignored
    abort = 1'b1; start = 1'b1;
    #1 chk("ab_read", {31'd0, read}, 32'd0);
    tick();
    abort = 1'b0; start = 1'b0;
    chk("ab_busy",  {31'd0, busy},      32'd0);
    chk("ab_done",  {31'd0, done},      32'd0);
    chk("ab_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("ab_count", {27'd0, sample_count}, 32'd8);
    chk("ab_peak",  {9'd0, peak},       32'h7FFFFF);
    tick();
    chk("ab_busy2", {31'd0, busy}, 32'd0);

    // restart clears count/peak; read_ready toggles 1,0,1,1,0
    mode = 2'b00; readdata_left = 24'h000010; readdata_right = 24'h000030;
    read_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_count0", {27'd0, sample_count}, 32'd0);
    chk("b_peak0",  {9'd0, peak},       32'd0);
    chk("b_busy",   {31'd0, busy},      32'd1);
    pulses = 0;
    nwr = 0;
    for (int k = 0; k < 5; k++) begin
      read_ready = rr_pat[k];
      #1;
      if (read) pulses++;
      tick();
      if (mem_wr_en) begin
        chk("b_addr", {28'd0, mem_addr}, nwr);
        nwr++;
      end
    end
    chk("b_pulses", pulses, 32'd3);
    chk("b_writes", nwr,    32'd3);
    chk("b_count",  {27'd0, sample_count}, 32'd3);

    // two more samples, then abort with the fifth write still on the port
    read_ready = 1'b1;
    tick();
    tick();
    abort = 1'b1;
    #1;
    chk("c_pend_wr", {31'd0, mem_wr_en}, 32'd1);
    chk("c_pend_ad", {28'd0, mem_addr},  32'd4);
    tick();
    abort = 1'b0;
    chk("c_busy",  {31'd0, busy},      32'd0);
    chk("c_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("c_count", {27'd0, sample_count}, 32'd5);

    // full buffer (16 words) with continuous read_ready
    mode = 2'b01; readdata_left = 24'h000100; readdata_right = 24'h7FFFFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("d_count0", {27'd0, sample_count}, 32'd0);
    chk("d_peak0",  {9'd0, peak},       32'd0);
    nwr = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      tick();
      if (mem_wr_en) begin
        chk("d_addr", {28'd0, mem_addr}, nwr);
        nwr++;
      end
    end
    chk("d_writes", nwr,                    32'd16);
    chk("d_done",   {31'd0, done},          32'd1);
    chk("d_busy",   {31'd0, busy},          32'd0);
    chk("d_count",  {27'd0, sample_count},  32'd16);
    chk("d_peak",   {9'd0, peak},           32'h100);
    chk("d_read",   {31'd0, read},          32'd0);
    tick();
    chk("d_wr_en2", {31'd0, mem_wr_en}, 32'd0);
    chk("d_read2",  {31'd0, read},      32'd0);
    chk("d_done2",  {31'd0, done},      32'd1);

    // restart from DONE, then async reset between edges
    mode = 2'b00; readdata_left = 24'h000010; readdata_right = 24'h000030;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("e_busy",   {31'd0, busy},         32'd1);
    chk("e_done",   {31'd0, done},         32'd0);
    chk("e_count0", {27'd0, sample_count}, 32'd0);
    tick();
    tick();
    chk("e_count",  {27'd0, sample_count}, 32'd2);
    chk("e_read",   {31'd0, read},         32'd1);
    chk("e_wr_en",  {31'd0, mem_wr_en},    32'd1);
    #2 reset = 1'b0;
    #1;
    chk("r_read",  {31'd0, read},      32'd0);
    chk("r_wr_en", {31'd0, mem_wr_en}, 32'd0);
    chk("r_busy",  {31'd0, busy},      32'd0);
    chk("r_done",  {31'd0, done},      32'd0);
    chk("r_addr",  {28'd0, mem_addr},  32'd0);
    chk("r_wdata", {8'd0, mem_wdata},  32'd0);
    chk("r_count", {27'd0, sample_count}, 32'd0);
    chk("r_peak",  {9'd0, peak},       32'd0);
    #3 reset = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_capture.md
Name: audio_capture

Overview:
Codec-read-side counterpart to the ROM/tone playback path. It drains samples from the audio_codec read FIFO using the read_ready/read handshake and converts each sample to mono. It writes the samples sequentially into an external single-port sample RAM of 2^ADDR_W words. It also tracks the peak magnitude of the capture so that the top level can drive LEDR/HEX with it and later play the buffer back through the existing writedata path.

Parameters:
DATA_W, 24, codec sample width (two's complement)
ADDR_W, 13, sample RAM address width; buffer depth = 2^ADDR_W (8192 words)

Ports:
clk  input  1  system clock (CLOCK_50 domain, same clock as audio_codec)
reset  input  1  asynchronous, active-low (0 = reset)
start  input  1  single-cycle pulse; begins a capture
abort  input  1  single-cycle pulse; stops a capture early
mode  input  2  00 = (L+R)/2, 01 = left only, 10 = right only, 11 = treated as 00
read_ready  input  1  codec read FIFO non-empty
readdata_left  input  DATA_W  codec left sample, valid while read_ready=1
readdata_right  input  DATA_W  codec right sample, valid while read_ready=1
read  output  1  codec pop strobe
mem_wr_en  output  1  RAM write enable
mem_addr  output  ADDR_W  RAM write address
mem_wdata  output  DATA_W  RAM write data
busy  output  1  1 while in CAPTURE
done  output  1  1 while in DONE
sample_count  output  ADDR_W+1  number of samples written in the current or last capture
peak  output  DATA_W-1  maximum |sample| seen in the current or last capture

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE; read=0; mem_wr_en=0; mem_addr=0; mem_wdata=0; busy=0; done=0; sample_count=0; peak=0.
- FSM states: IDLE, CAPTURE, DONE.
  - IDLE, start=1 -> CAPTURE. On entry, sample_count and peak are cleared to 0.
  - CAPTURE, abort=1 -> IDLE. sample_count and peak hold their values.
  - CAPTURE, last write issued (sample_count reaches 2^ADDR_W) -> DONE.
  - DONE, start=1 -> CAPTURE, with the same clears as from IDLE.
  - DONE, abort=1 -> IDLE.
  - start and abort in the same cycle: abort wins. start in CAPTURE is ignored.
- Handshake:
  - read is combinational: read = (state==CAPTURE) & read_ready & ~abort & (sample_count < 2^ADDR_W).
  - Data is sampled in the same cycle read=1 (show-ahead FIFO).
  - read may stay high on back-to-back cycles; each high cycle pops exactly one stereo pair.
  - read is never asserted outside CAPTURE.
- Mono conversion, computed on the cycle read=1:
  - mode 00: sign-extend L and R to DATA_W+1 bits, add, arithmetic shift right by 1, truncate to DATA_W.
  - mode 01: L passes through unchanged. mode 10: R passes through unchanged.
- Write pipeline, latency 1:
  - The cycle after a read pulse: mem_wr_en=1, mem_addr=sample_count[ADDR_W-1:0] (pre-increment value), mem_wdata=converted sample.
  - sample_count increments in that same cycle.
  - mem_wr_en is 0 in every other cycle.
- Completion and abort:
  - The write with mem_addr=2^ADDR_W-1 is the final one; sample_count becomes 2^ADDR_W and the FSM enters DONE in the same edge.
  - The address never wraps.
  - If abort coincides with a pending write (read high in the previous cycle), that write still completes.
- Peak:
  - |x| is computed from the converted sample; |-2^(DATA_W-1)| saturates to 2^(DATA_W-1)-1.
  - peak <= max(peak, |x|), updated on the same cycle as mem_wr_en.
- busy and done are registered decodes of the state.
- Asynchronous reset mid-capture returns to IDLE immediately with all outputs at their reset values.

Decomposition:
- Package audio_pkg holds:
  - cap_state_t enum {IDLE, CAPTURE, DONE}
  - mode constants MODE_MIX=2'b00, MODE_LEFT=2'b01, MODE_RIGHT=2'b10
  - SAMPLE_W=24
- One sub-module: sample_mono (combinational mode select, mix and saturating abs). It is reused later by the playback and VU-meter paths.

Test Plan:
- Reset, then start with mode=00, L=24'h000010, R=24'h000030, read_ready held at 1 -> read high from the cycle after start. First write is mem_addr=0, mem_wdata=24'h000020, one cycle after the first read.
- mode=00, L=24'h7FFFFF, R=24'h7FFFFF -> mem_wdata=24'h7FFFFF with no overflow. L=24'h800000, R=24'h800000 -> mem_wdata=24'h800000 and peak=23'h7FFFFF (saturated).
- read_ready toggling 1,0,1,1,0 during CAPTURE -> exactly 3 read pulses, 3 writes at addresses 0,1,2, and sample_count=3.
- ADDR_W=4 with continuous read_ready -> 16 writes (addresses 0..15), then done=1, busy=0, and read=0 thereafter even though read_ready=1.
- Abort after 5 samples -> busy=0, sample_count=5. A start in the same cycle as abort is ignored; a later start clears sample_count and peak to 0.
- Drive reset=0 asynchronously mid-capture, between clock edges -> read, mem_wr_en and busy drop immediately, and all outputs take their reset values.
